// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: repeating up-counter sequencer.
// One accepted start runs the counter 0..lim a total of reps+1 times,
// pulsing wrap at every terminal count and done once at the very end.
// pause freezes a run, abort (or rst) cancels it without any pulses.
module count_seq_ctrl #(
  parameter int WIDTH = 3,
  parameter int REPW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic [REPW-1:0]  reps,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic [REPW-1:0]  reps_left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [REPW-1:0]  reps_left_q, reps_left_d;
  logic             busy_q, busy_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  // Terminal count is an equality test against the captured limit, so a
  // limit of all-ones is reached before q could ever overflow.
  logic at_limit;
  assign at_limit = (q_q == lim_q);

  // Next-state and next-output logic; wrap/done default low so they are
  // single-cycle pulses unless a terminal count re-asserts them.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    lim_d       = lim_q;
    reps_left_d = reps_left_q;
    busy_d      = busy_q;
    wrap_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d     = RUN;
          lim_d       = limit;
          reps_left_d = reps;
          q_d         = '0;
          busy_d      = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          // abort outranks both pause and terminal-count detection
          state_d     = IDLE;
          q_d         = '0;
          busy_d      = 1'b0;
          reps_left_d = '0;
        end else if (!pause) begin
          if (!at_limit) begin
            q_d = q_q + WIDTH'(1);
          end else if (reps_left_q != '0) begin
            wrap_d      = 1'b1;
            q_d         = '0;
            reps_left_d = reps_left_q - REPW'(1);
          end else begin
            // final run complete: q stays parked at the limit
            wrap_d  = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // single-cycle state; start is not looked at here
        state_d = IDLE;
        busy_d  = 1'b0;
        if (abort) begin
          q_d         = '0;
          reps_left_d = '0;
        end
      end

      default: begin
        state_d     = IDLE;
        q_d         = '0;
        busy_d      = 1'b0;
        reps_left_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      q_q         <= '0;
      lim_q       <= '0;
      reps_left_q <= '0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      lim_q       <= lim_d;
      reps_left_q <= reps_left_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
    end
  end

  assign q         = q_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;
  assign done      = done_q;
  assign reps_left = reps_left_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed plus randomized checks of count_seq_ctrl
// against a progress-based reference model.
module tb_count_seq_ctrl;

  localparam int WIDTH = 3;
  localparam int REPW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] limit;
  logic [REPW-1:0]  reps;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             wrap;
  logic             done;
  logic [REPW-1:0]  reps_left;

  int n_checks = 0;
  int n_fail   = 0;

  count_seq_ctrl #(.WIDTH(WIDTH), .REPW(REPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .limit     (limit),
    .reps      (reps),
    .pause     (pause),
    .abort     (abort),
    .q         (q),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done),
    .reps_left (reps_left)
  );

  always #5 clk = ~clk;

  // Reference model. A run is described by p, the number of unpaused RUN
  // edges since the accept edge: q = p mod (L+1), completed runs =
  // p div (L+1), and the run ends when p = (R+1)*(L+1).
  int m_phase = 0;  // 0 idle, 1 running, 2 done cycle
  int m_p     = 0;
  int m_L     = 0;
  int m_R     = 0;
  int m_adv   = 0;  // last edge advanced the run
  int m_qhold = 0;  // q shown while idle

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = 0;
      m_qhold = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_p     = 0;
          m_L     = int'(limit);
          m_R     = int'(reps);
          m_adv   = 0;
        end
        1: begin
          if (abort) begin
            m_phase = 0;
            m_qhold = 0;
          end else if (pause) begin
            m_adv = 0;
          end else begin
            m_p++;
            m_adv = 1;
            if (m_p == (m_R + 1) * (m_L + 1)) m_phase = 2;
          end
        end
        default: begin
          m_phase = 0;
          m_qhold = abort ? 0 : m_L;
        end
      endcase
    end
  endtask

  task automatic model_check();
    int eq, eb, ew, ed, er;
    case (m_phase)
      0: begin eq = m_qhold; eb = 0; ew = 0; ed = 0; er = 0; end
      1: begin
        eq = m_p % (m_L + 1);
        eb = 1;
        ew = (m_adv == 1 && m_p > 0 && (m_p % (m_L + 1)) == 0) ? 1 : 0;
        ed = 0;
        er = m_R - m_p / (m_L + 1);
      end
      default: begin eq = m_L; eb = 0; ew = 1; ed = 1; er = 0; end
    endcase
    chk("model_q", int'(q), eq);
    chk("model_busy", int'(busy), eb);
    chk("model_wrap", int'(wrap), ew);
    chk("model_done", int'(done), ed);
    chk("model_reps_left", int'(reps_left), er);
  endtask

  // One clock: model follows the edge, outputs compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  initial begin
    int seen;
    int cyc;

    rst = 1'b1; start = 1'b0; limit = '0; reps = '0; pause = 1'b0; abort = 1'b0;

    // reset held two cycles
    tick(); tick();
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_reps_left", int'(reps_left), 0);
    rst = 1'b0;
    tick();

    // limit=3 reps=0: q 0,1,2,3 then wrap+done, q parks at 3
    start = 1'b1; limit = 3'd3; reps = 2'd0;
    tick();
    chk("l3_accept_q", int'(q), 0);
    chk("l3_accept_busy", int'(busy), 1);
    start = 1'b0; limit = 3'd1;  // later changes must not matter
    tick(); chk("l3_q1", int'(q), 1);
    tick(); chk("l3_q2", int'(q), 2);
    tick(); chk("l3_q3", int'(q), 3); chk("l3_no_wrap_yet", int'(wrap), 0);
    tick();
    chk("l3_wrap", int'(wrap), 1);
    chk("l3_done", int'(done), 1);
    chk("l3_q_hold", int'(q), 3);
    chk("l3_busy_low", int'(busy), 0);
    start = 1'b1;  // ignored in DONE
    tick();
    start = 1'b0;
    chk("l3_done_pulse_end", int'(done), 0);
    chk("l3_idle_q", int'(q), 3);
    chk("l3_start_in_done_ignored", int'(busy), 0);
    tick();

    // limit=2 reps=2: three runs of 0,1,2 then a single done
    start = 1'b1; limit = 3'd2; reps = 2'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      chk("l2r2_q_seq", int'(q), i % 3);
      chk("l2r2_reps_left", int'(reps_left), 2 - i / 3);
      chk("l2r2_no_done", int'(done), 0);
    end
    tick();
    chk("l2r2_final_done", int'(done), 1);
    chk("l2r2_final_q", int'(q), 2);
    tick();

    // limit=5 with 3 paused cycles at q=2: wrap 3 cycles late (9 vs 6)
    start = 1'b1; limit = 3'd5; reps = 2'd0;
    tick();
    start = 1'b0;
    cyc = 0; seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      pause = (q == 3'd2 && cyc >= 2 && cyc < 5) ? 1'b1 : 1'b0;
      tick();
      cyc++;
      if (pause) chk("pause_q_held", int'(q), 2);
      if (wrap) seen = 1;
    end
    pause = 1'b0;
    chk("pause_wrap_latency", cyc, 9);
    tick();

    // abort together with pause and start at q=4, limit=6
    start = 1'b1; limit = 3'd6; reps = 2'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && q != 3'd4; i++) tick();
    chk("abort_reached_q4", int'(q), 4);
    abort = 1'b1; pause = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; pause = 1'b0; start = 1'b0;
    chk("abort_q", int'(q), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_wrap", int'(wrap), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_reps_left", int'(reps_left), 0);
    tick();
    chk("abort_start_ignored", int'(busy), 0);

    // limit=0 reps=1: wrap on two consecutive cycles, done with the second
    start = 1'b1; limit = 3'd0; reps = 2'd1;
    tick();
    start = 1'b0;
    tick();
    chk("l0_wrap1", int'(wrap), 1);
    chk("l0_done1", int'(done), 0);
    tick();
    chk("l0_wrap2", int'(wrap), 1);
    chk("l0_done2", int'(done), 1);
    tick();

    // limit=7 then rst mid-run
    start = 1'b1; limit = 3'd7; reps = 2'd3;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_q", int'(q), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_wrap", int'(wrap), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_reps_left", int'(reps_left), 0);

    // full-range run, limit=7: first wrap 8 cycles after accept
    start = 1'b1; limit = 3'd7; reps = 2'd0;
    tick();
    start = 1'b0;
    cyc = 0; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      cyc++;
      if (wrap) seen = 1;
    end
    chk("l7_wrap_latency", cyc, 8);
    chk("l7_q_at_done", int'(q), 7);
    tick();

    // randomized traffic, model checked every cycle
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      pause = ($urandom_range(0, 3) == 0);
      abort = (m_phase != 0) && ($urandom_range(0, 24) == 0);
      limit = WIDTH'($urandom);
      reps  = REPW'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
